// File: rtl/fold_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fold_pkg
//  Description : Shared constants, FSM state encoding and sample types for the
//                modulo-folding encoder (fold_generator / fold_cell).
//  Revision    : 1.0 - initial release
// ============================================================================
package fold_pkg;

    localparam int c_rows    = 32;
    localparam int c_in_res  = 20;
    localparam int c_out_res = 16;
    localparam int c_l_log2  = 12;
    localparam int c_l       = 1 << c_l_log2;
    localparam int c_two_l   = 2 * c_l;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fold_state_t;

    typedef logic signed [c_in_res-1:0]  in_sample_t;
    typedef logic signed [c_out_res-1:0] out_sample_t;

endpackage
`default_nettype wire

// File: rtl/fold_cell.sv
`default_nettype none
// ============================================================================
//  Module      : fold_cell
//  Description : Combinational single-sample fold: x -> centred modulo sample
//                y in [-L, L) and fold index k = floor((x + L) / 2L).
//  Revision    : 1.0 - initial release
// ============================================================================
module fold_cell
    import fold_pkg::*;
#(
    parameter int IN_RES  = c_in_res,
    parameter int OUT_RES = c_out_res,
    parameter int L_LOG2  = c_l_log2
) (
    input  logic signed [IN_RES-1:0]        x,
    output logic signed [OUT_RES-1:0]       y,
    output logic signed [IN_RES-L_LOG2-1:0] k
);

    localparam logic signed [IN_RES:0] c_l_ext = (IN_RES+1)'(1) << L_LOG2;

    logic signed [IN_RES:0] w_s;
    logic signed [L_LOG2:0] w_y_short;

    // One guard bit makes x + L overflow-free.
    assign w_s = {x[IN_RES-1], x} + c_l_ext;

    // Upper bits of s are floor(s / 2L); subtracting L from the low field
    // is the same as inverting its top bit.
    assign k         = w_s[IN_RES:L_LOG2+1];
    assign w_y_short = {~w_s[L_LOG2], w_s[L_LOG2-1:0]};
    assign y         = OUT_RES'(w_y_short);

endmodule
`default_nettype wire

// File: rtl/fold_generator.sv
`default_nettype none
// ============================================================================
//  Module      : fold_generator
//  Description : Frame-based modulo-folding encoder, one sample per clock with
//                a start/busy/done handshake. Define FOLD_INDEX_EN to expose
//                the per-sample fold index on port fold_idx.
//  Revision    : 1.0 - initial release
// ============================================================================
module fold_generator
    import fold_pkg::*;
#(
    parameter int ROWS    = c_rows,
    parameter int IN_RES  = c_in_res,
    parameter int OUT_RES = c_out_res,
    parameter int L_LOG2  = c_l_log2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic signed [IN_RES-1:0]  in       [ROWS],
    output logic signed [OUT_RES-1:0] out      [ROWS],
    output logic                      busy,
    output logic                      done,
    output logic [5:0]                fold_cnt
`ifdef FOLD_INDEX_EN
    ,
    output logic signed [IN_RES-L_LOG2-1:0] fold_idx [ROWS]
`endif
);

    localparam int c_idx_w = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_cnt_w = $clog2(ROWS + 1);
    localparam int c_k_w   = IN_RES - L_LOG2;

    fold_state_t r_state;
    fold_state_t w_state_nxt;

    logic signed [IN_RES-1:0]  r_snap [ROWS];
    logic signed [OUT_RES-1:0] r_out  [ROWS];
`ifdef FOLD_INDEX_EN
    logic signed [c_k_w-1:0]   r_fold_idx [ROWS];
`endif

    logic [c_cnt_w-1:0]        r_idx;
    logic [c_idx_w-1:0]        w_sel;
    logic                      w_issue;
    logic signed [OUT_RES-1:0] w_y;
    logic signed [c_k_w-1:0]   w_k;

    logic                      r_p_vld;
    logic [c_idx_w-1:0]        r_p_idx;
    logic signed [OUT_RES-1:0] r_p_y;
    logic signed [c_k_w-1:0]   r_p_k;
    logic signed [c_k_w-1:0]   r_k_prev;
    logic [5:0]                r_fold_cnt;

    assign w_issue = (r_state == ST_RUN) && (r_idx < c_cnt_w'(ROWS));
    assign w_sel   = r_idx[c_idx_w-1:0];

    fold_cell #(
        .IN_RES  (IN_RES),
        .OUT_RES (OUT_RES),
        .L_LOG2  (L_LOG2)
    ) u_cell (
        .x (r_snap[w_sel]),
        .y (w_y),
        .k (w_k)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The frame ends when the last pipelined sample is written, not when it
    // is issued, so that done coincides with a fully updated out[].
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_p_vld && (r_p_idx == c_idx_w'(ROWS - 1))) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx      <= '0;
            r_p_vld    <= 1'b0;
            r_p_idx    <= '0;
            r_p_y      <= '0;
            r_p_k      <= '0;
            r_k_prev   <= '0;
            r_fold_cnt <= '0;
            for (int i = 0; i < ROWS; i++) begin
                r_snap[i] <= '0;
                r_out[i]  <= '0;
`ifdef FOLD_INDEX_EN
                r_fold_idx[i] <= '0;
`endif
            end
        end else begin
            r_p_vld <= w_issue;

            if ((r_state == ST_IDLE) && en) begin
                r_snap     <= in;
                r_idx      <= '0;
                r_fold_cnt <= '0;
            end

            if (w_issue) begin
                r_p_idx <= w_sel;
                r_p_y   <= w_y;
                r_p_k   <= w_k;
                r_idx   <= r_idx + c_cnt_w'(1);
            end

            // Write-back stage; the first sample of a frame has no predecessor.
            if (r_p_vld) begin
                r_out[r_p_idx] <= r_p_y;
`ifdef FOLD_INDEX_EN
                r_fold_idx[r_p_idx] <= r_p_k;
`endif
                r_k_prev <= r_p_k;
                if ((r_p_idx != '0) && (r_p_k != r_k_prev) && (r_fold_cnt != 6'd63)) begin
                    r_fold_cnt <= r_fold_cnt + 6'd1;
                end
            end
        end
    end

    assign out      = r_out;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign fold_cnt = r_fold_cnt;
`ifdef FOLD_INDEX_EN
    assign fold_idx = r_fold_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fold_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fold_generator
//  Description : Directed self-checking bench for fold_generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fold_generator;
    import fold_pkg::*;

    localparam int ROWS    = 32;
    localparam int IN_RES  = 20;
    localparam int OUT_RES = 16;
    localparam int L_LOG2  = 12;
    localparam int KW      = IN_RES - L_LOG2;
    localparam int L       = 1 << L_LOG2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b0;
    logic signed [IN_RES-1:0]  in  [ROWS];
    logic signed [OUT_RES-1:0] out [ROWS];
    logic       busy;
    logic       done;
    logic [5:0] fold_cnt;
`ifdef FOLD_INDEX_EN
    logic signed [KW-1:0] fold_idx [ROWS];
`endif

    fold_generator #(
        .ROWS    (ROWS),
        .IN_RES  (IN_RES),
        .OUT_RES (OUT_RES),
        .L_LOG2  (L_LOG2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .in       (in),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .fold_cnt (fold_cnt)
`ifdef FOLD_INDEX_EN
        ,
        .fold_idx (fold_idx)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference fold: ((x + L) mod 2L) - L with a non-negative modulus.
    function automatic int fold_ref(input int x);
        int m;
        m = (x + L) % (2 * L);
        if (m < 0) m += 2 * L;
        return m - L;
    endfunction

    task automatic set_all(input int v);
        for (int i = 0; i < ROWS; i++) in[i] = IN_RES'(v);
    endtask

    task automatic start_frame(output int t);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        t  = cyc;
        en = 1'b0;
    endtask

    // Waits until the frame leaves busy; returns done cycle, busy cycles, done pulses.
    task automatic wait_done(output int dcyc, output int nbusy, output int ndone);
        dcyc  = -1;
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = cyc;
            end
            if (!busy) break;
        end
        if (busy) check("timeout_busy", 1, 0);
        if (dcyc < 0) check("timeout_done", 0, 1);
    endtask

    int xs [5] = '{4095, 4096, -4096, 5000, -12289};
    int ys [5] = '{4095, -4096, -4096, -3192, 4095};
    int ks [5] = '{0, 1, 0, 1, -2};

    initial begin
        int t, dcyc, nbusy, ndone, bad, e0, d1, d2, gap_busy;
        set_all(0);

        repeat (3) @(negedge clk);
        check("rst_out0", int'(out[0]), 0);
        check("rst_out31", int'(out[ROWS-1]), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fold_cnt", int'(fold_cnt), 0);
        reset = 1'b1;

        // Single values, every sample identical so no folds are counted.
        for (int v = 0; v < 5; v++) begin
            set_all(xs[v]);
            start_frame(t);
            wait_done(dcyc, nbusy, ndone);
            check($sformatf("single_out0_%0d", xs[v]), int'(out[0]), ys[v]);
            check($sformatf("single_out31_%0d", xs[v]), int'(out[ROWS-1]), ys[v]);
            check($sformatf("single_cnt_%0d", xs[v]), int'(fold_cnt), 0);
`ifdef FOLD_INDEX_EN
            check($sformatf("single_k_%0d", xs[v]), int'(fold_idx[0]), ks[v]);
`endif
        end

        // Ramp frame with latency and handshake timing.
        for (int i = 0; i < ROWS; i++) in[i] = IN_RES'(1000 * i);
        start_frame(t);
        dcyc  = -1;
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = cyc;
            end
            if (cyc == t + 1) check("ramp_out0_old", int'(out[0]), 4095);
            if (cyc == t + 2) check("ramp_out0_new", int'(out[0]), 0);
            if (cyc == t + ROWS) check("ramp_out31_old", int'(out[ROWS-1]), 4095);
            if (cyc == t + ROWS + 1) check("ramp_out31_new", int'(out[ROWS-1]), fold_ref(1000 * (ROWS - 1)));
            if (!busy) break;
        end
        check("ramp_done_cycle", dcyc - t, ROWS + 1);
        check("ramp_done_pulses", ndone, 1);
        check("ramp_busy_cycles", nbusy, ROWS + 2);
        check("ramp_fold_cnt", int'(fold_cnt), 4);
        bad = 0;
        for (int i = 0; i < ROWS; i++) if (int'(out[i]) != fold_ref(1000 * i)) bad++;
        check("ramp_out_bad", bad, 0);

        // Alternating +/-4100.
        for (int i = 0; i < ROWS; i++) in[i] = IN_RES'((i % 2 == 0) ? 4100 : -4100);
        start_frame(t);
        wait_done(dcyc, nbusy, ndone);
        check("alt_out0", int'(out[0]), -4092);
        check("alt_out1", int'(out[1]), 4092);
        check("alt_fold_cnt", int'(fold_cnt), 31);
`ifdef FOLD_INDEX_EN
        check("alt_k1", int'(fold_idx[1]), -1);
`endif

        // Snapshot isolation: input changes after capture are ignored.
        set_all(0);
        start_frame(t);
        @(posedge clk);
        #1;
        set_all(7000);
        wait_done(dcyc, nbusy, ndone);
        bad = 0;
        for (int i = 0; i < ROWS; i++) if (out[i] != 0) bad++;
        check("snap_out_nonzero", bad, 0);
        check("snap_fold_cnt", int'(fold_cnt), 0);

        // Asynchronous reset during the 10th RUN cycle.
        for (int i = 0; i < ROWS; i++) in[i] = IN_RES'(1000 * i);
        start_frame(t);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc >= t + 9) break;
        end
        check("mid_out5", int'(out[5]), -3192);
        check("mid_fold_cnt", int'(fold_cnt), 1);
        reset = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < ROWS; i++) if (out[i] != 0) bad++;
        check("arst_out_nonzero", bad, 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_fold_cnt", int'(fold_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < ROWS; i++) in[i] = IN_RES'((i % 2 == 0) ? 4100 : -4100);
        start_frame(t);
        wait_done(dcyc, nbusy, ndone);
        check("post_rst_done_cycle", dcyc - t, ROWS + 1);
        check("post_rst_out31", int'(out[ROWS-1]), 4092);
        check("post_rst_fold_cnt", int'(fold_cnt), 31);

        // en held high: back-to-back frames with one idle cycle between them.
        set_all(4095);
        @(negedge clk);
        en       = 1'b1;
        e0       = -1;
        d1       = -1;
        d2       = -1;
        ndone    = 0;
        gap_busy = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy && e0 < 0) e0 = cyc;
            if (done) begin
                ndone++;
                if (d1 < 0) d1 = cyc;
                else if (d2 < 0) d2 = cyc;
            end
            if (e0 >= 0 && cyc == e0 + ROWS + 2) gap_busy = int'(busy);
        end
        en = 1'b0;
        check("hold_done_pulses", ndone, 2);
        check("hold_first_done", d1 - e0, ROWS + 1);
        check("hold_done_period", d2 - d1, ROWS + 3);
        check("hold_gap_busy", gap_busy, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("hold_final_busy", int'(busy), 0);
        check("hold_out0", int'(out[0]), 4095);
        check("hold_fold_cnt", int'(fold_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
